// File: rtl/ym3438_dac_demux.sv
// YM3438 DAC output demultiplexer.
// Follows the 24-slot TDM sample stream, gathers the six channel samples
// into shadow registers and publishes a complete frame on ch_out.
//
// state    | meaning
// ---------+---------------------------------------------------------
// UNLOCKED | no frame alignment; waiting for a strobe with sync=1
// LOCKED   | slot counter aligned; capturing channels on slots 0,4..20
module ym3438_dac_demux (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        c1,
    input  logic        sync,
    input  logic [8:0]  dac_in,
    input  logic        err_clr,
    output logic [53:0] ch_out,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_err
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       slot_hi;
    logic [1:0]       slot_lo;
    // shadow[0] holds ch1 ... shadow[4] holds ch5; ch6 goes straight to ch_out
    logic [4:0][8:0]  shadow;
    // one bit per shadow register captured since the last slot 0
    logic [4:0]       cap_mask;

    logic [2:0]       exp_hi;
    logic [1:0]       exp_lo;
    logic [4:0]       exp_slot;
    logic             exp_is_zero;
    logic             exp_is_cap;
    logic [2:0]       cap_idx;

    // Expected slot for the coming strobe: previous slot + 1 with 23 -> 0 wrap.
    always_comb begin
        exp_lo = (slot_lo == 2'd2) ? 2'd0 : slot_lo + 2'd1;
        exp_hi = slot_hi;
        if (slot_lo == 2'd2) begin
            exp_hi = (slot_hi == 3'd7) ? 3'd0 : slot_hi + 3'd1;
        end
        exp_slot    = {exp_hi, 1'b0} + {2'b00, exp_hi} + {3'b000, exp_lo};
        exp_is_zero = (exp_hi == 3'd0) && (exp_lo == 2'd0);
        exp_is_cap  = (exp_slot[1:0] == 2'b00);
        cap_idx     = exp_slot[4:2];
    end

    assign locked = (state == LOCKED);

    // Slot tracking, channel capture, frame publish and error flag.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state       <= UNLOCKED;
            slot_hi     <= 3'd0;
            slot_lo     <= 2'd0;
            shadow      <= '0;
            cap_mask    <= 5'd0;
            ch_out      <= 54'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            // a new error below overrides this clear
            if (err_clr) begin
                sync_err <= 1'b0;
            end
            if (c1) begin
                case (state)
                    UNLOCKED: begin
                        if (sync) begin
                            state     <= LOCKED;
                            slot_hi   <= 3'd0;
                            slot_lo   <= 2'd0;
                            shadow[0] <= dac_in;
                            cap_mask  <= 5'b00001;
                        end
                    end
                    LOCKED: begin
                        if (sync) begin
                            // sync off the expected position restarts the frame
                            if (!exp_is_zero) begin
                                sync_err <= 1'b1;
                            end
                            slot_hi   <= 3'd0;
                            slot_lo   <= 2'd0;
                            shadow[0] <= dac_in;
                            cap_mask  <= 5'b00001;
                        end else if (exp_is_zero) begin
                            sync_err <= 1'b1;
                            state    <= UNLOCKED;
                            slot_hi  <= 3'd0;
                            slot_lo  <= 2'd0;
                            cap_mask <= 5'd0;
                        end else begin
                            slot_hi <= exp_hi;
                            slot_lo <= exp_lo;
                            if (exp_is_cap) begin
                                if (cap_idx == 3'd5) begin
                                    if (&cap_mask) begin
                                        ch_out      <= {dac_in, shadow};
                                        frame_valid <= 1'b1;
                                    end
                                end else begin
                                    shadow[cap_idx]   <= dac_in;
                                    cap_mask[cap_idx] <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ym3438_dac_demux.sv
// Directed bench for ym3438_dac_demux.
module tb_ym3438_dac_demux;

    logic        MCLK = 1'b0;
    logic        reset = 1'b1;
    logic        c1 = 1'b0;
    logic        sync = 1'b0;
    logic [8:0]  dac_in = 9'd0;
    logic        err_clr = 1'b0;
    logic [53:0] ch_out;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;

    int vectors = 0;
    int miscompares = 0;
    int strobe_idx = 0;
    logic last_fv = 1'b0;

    int   fv_total = 0;
    int   fv_consec = 0;
    logic fv_prev = 1'b0;

    ym3438_dac_demux dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .c1          (c1),
        .sync        (sync),
        .dac_in      (dac_in),
        .err_clr     (err_clr),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 MCLK = ~MCLK;

    always @(negedge MCLK) begin
        if (frame_valid) fv_total++;
        if (frame_valid && fv_prev) fv_consec++;
        fv_prev = frame_valid;
    end

    // One strobe edge followed by one idle edge; idle drives noise on the
    // qualified inputs, which must be ignored with c1=0.
    task automatic strobe(input logic s, input logic [8:0] d, input logic clr);
        c1 = 1'b1; sync = s; dac_in = d; err_clr = clr;
        @(negedge MCLK);
        strobe_idx++;
        last_fv = frame_valid;
        c1 = 1'b0; sync = 1'b1; dac_in = 9'h155; err_clr = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic do_reset();
        reset = 1'b1; c1 = 1'b1; sync = 1'b1; dac_in = 9'h1AA; err_clr = 1'b0;
        @(negedge MCLK);
        @(negedge MCLK);
        reset = 1'b0; c1 = 1'b0; sync = 1'b0; dac_in = 9'd0;
        @(negedge MCLK);
    endtask

    function automatic logic [53:0] pack6(input int base);
        logic [53:0] v;
        for (int k = 0; k < 6; k++) v[k*9 +: 9] = 9'(base + 4*k);
        return v;
    endfunction

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({ch_out, frame_valid, locked, sync_err} !== 57'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ch_out=%h fv=%b locked=%b err=%b, want all 0",
                     ch_out, frame_valid, locked, sync_err);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int s = 0; s < 24; s++) begin
            strobe(s == 0, 9'(s), 1'b0);
            vectors++;
            if (last_fv !== (s == 20)) begin
                miscompares++;
                $display("FAIL basic_fv slot %0d: got %b want %b", s, last_fv, (s == 20));
            end
            if (s == 19) begin
                vectors++;
                if (ch_out !== 54'd0) begin
                    miscompares++;
                    $display("FAIL basic_hold_before: got %h want 0", ch_out);
                end
            end
        end
        vectors++;
        if (ch_out !== pack6(0)) begin
            miscompares++;
            $display("FAIL basic_ch_out: got %h want %h", ch_out, pack6(0));
        end
        vectors++;
        if (locked !== 1'b1 || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_status: got locked=%b err=%b want 1 0", locked, sync_err);
        end
    endtask

    task automatic test_wrap();
        int pos[$];
        int base;
        do_reset();
        base = strobe_idx;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 24; s++) begin
                strobe(s == 0, 9'h1FF, 1'b0);
                if (last_fv) pos.push_back(strobe_idx - base - 1);
            end
        end
        vectors++;
        if (pos.size() !== 3) begin
            miscompares++;
            $display("FAIL wrap_pulse_count: got %0d want 3", pos.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (pos[i] !== 20 + 24*i) begin
                    miscompares++;
                    $display("FAIL wrap_pulse_pos %0d: got %0d want %0d", i, pos[i], 20 + 24*i);
                end
            end
        end
        vectors++;
        if (ch_out !== {6{9'h1FF}} || sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_final: got ch_out=%h err=%b want all 1ff err=0", ch_out, sync_err);
        end
    endtask

    task automatic test_early_sync();
        int fv_start;
        do_reset();
        fv_start = fv_total;
        for (int s = 0; s < 10; s++) strobe(s == 0, 9'(s + 30), 1'b0);
        strobe(1'b1, 9'd100, 1'b0);
        vectors++;
        if (sync_err !== 1'b1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL early_flag: got err=%b locked=%b want 1 1", sync_err, locked);
        end
        for (int s = 1; s < 24; s++) begin
            strobe(1'b0, 9'(100 + s), 1'b0);
            if (s == 19) begin
                vectors++;
                if (ch_out !== 54'd0) begin
                    miscompares++;
                    $display("FAIL early_aborted_frame: got %h want 0", ch_out);
                end
            end
        end
        vectors++;
        if (ch_out !== pack6(100)) begin
            miscompares++;
            $display("FAIL early_next_frame: got %h want %h", ch_out, pack6(100));
        end
        vectors++;
        if (fv_total - fv_start !== 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL early_pulses: got %0d pulses locked=%b want 1 pulse locked=1",
                     fv_total - fv_start, locked);
        end
    endtask

    task automatic test_missing_sync();
        int fv_start;
        do_reset();
        for (int s = 0; s < 24; s++) strobe(s == 0, 9'(s), 1'b0);
        strobe(1'b0, 9'd7, 1'b0);
        vectors++;
        if (locked !== 1'b0 || sync_err !== 1'b1) begin
            miscompares++;
            $display("FAIL missing_flag: got locked=%b err=%b want 0 1", locked, sync_err);
        end
        fv_start = fv_total;
        for (int s = 0; s < 30; s++) strobe(1'b0, 9'(50 + s), 1'b0);
        vectors++;
        if (locked !== 1'b0 || fv_total !== fv_start || ch_out !== pack6(0)) begin
            miscompares++;
            $display("FAIL missing_ignore: got locked=%b pulses=%0d ch_out=%h want 0 0 %h",
                     locked, fv_total - fv_start, ch_out, pack6(0));
        end
        for (int s = 0; s < 24; s++) strobe(s == 0, 9'(200 + s), 1'b0);
        vectors++;
        if (ch_out !== pack6(200) || locked !== 1'b1 || sync_err !== 1'b1) begin
            miscompares++;
            $display("FAIL missing_relock: got ch_out=%h locked=%b err=%b want %h 1 1",
                     ch_out, locked, sync_err, pack6(200));
        end
    endtask

    task automatic test_err_clr_race();
        do_reset();
        for (int s = 0; s < 5; s++) strobe(s == 0, 9'(s), 1'b0);
        strobe(1'b1, 9'd9, 1'b1);
        vectors++;
        if (sync_err !== 1'b1) begin
            miscompares++;
            $display("FAIL race_error_wins: got %b want 1", sync_err);
        end
        err_clr = 1'b1;
        @(negedge MCLK);
        err_clr = 1'b0;
        vectors++;
        if (sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL race_clear: got %b want 0", sync_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int s = 0; s < 24; s++) strobe(s == 0, 9'(s + 1), 1'b0);
        for (int s = 0; s <= 12; s++) strobe(s == 0, 9'(s + 60), 1'b0);
        vectors++;
        if (ch_out !== pack6(1)) begin
            miscompares++;
            $display("FAIL midrst_pre: got %h want %h", ch_out, pack6(1));
        end
        do_reset();
        vectors++;
        if ({ch_out, frame_valid, locked, sync_err} !== 57'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got ch_out=%h fv=%b locked=%b err=%b want all 0",
                     ch_out, frame_valid, locked, sync_err);
        end
        strobe(1'b0, 9'd13, 1'b0);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_lock: got %b want 0", locked);
        end
        strobe(1'b1, 9'd80, 1'b0);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_lock: got %b want 1", locked);
        end
        for (int s = 1; s < 24; s++) strobe(1'b0, 9'(80 + s), 1'b0);
        vectors++;
        if (ch_out !== pack6(80)) begin
            miscompares++;
            $display("FAIL midrst_frame: got %h want %h", ch_out, pack6(80));
        end
    endtask

    task automatic test_pulse_width();
        vectors++;
        if (fv_consec !== 0) begin
            miscompares++;
            $display("FAIL fv_consecutive: got %0d back-to-back pulses want 0", fv_consec);
        end
    endtask

    initial begin
        @(negedge MCLK);
        test_reset();
        test_basic_frame();
        test_wrap();
        test_early_sync();
        test_missing_sync();
        test_err_clr_race();
        test_reset_mid_frame();
        test_pulse_width();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ym3438_dac_demux.md
YM3438_DAC_DEMUX -- requirements
Module: ym3438_dac_demux

Interface
REQ-001 SHALL have port MCLK  in  1  the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset; overrides every other input.
REQ-003 SHALL have port c1  in  1  slot strobe; one MCLK cycle high per TDM slot; the current slot is the one in which c1=1.
REQ-004 SHALL have port sync  in  1  frame marker; qualified only when c1=1; high means the current slot is slot 0.
REQ-005 SHALL have port dac_in  in  9  signed two's-complement channel sample; qualified only when c1=1.
REQ-006 SHALL have port err_clr  in  1  clears sync_err.
REQ-007 SHALL have port ch_out  out  54  six 9-bit channel samples; ch1 in bits [8:0], ch6 in bits [53:45].
REQ-008 SHALL have port frame_valid  out  1  single-cycle pulse when ch_out updates.
REQ-009 SHALL have port locked  out  1  high in state LOCKED.
REQ-010 SHALL have port sync_err  out  1  sticky frame-alignment error flag.

Function
REQ-011 SHALL track the slot position in a 24-slot frame as a {high[2:0], low[1:0]} counter; low counts 0..2, high counts 0..7; slot = high*3+low.
REQ-012 SHALL perform all tracking, capture and error updates only on MCLK edges with c1=1, except err_clr and reset; between strobes all state is held.
REQ-013 SHALL use two states: UNLOCKED (the reset state) and LOCKED.
REQ-014 In UNLOCKED, SHALL ignore dac_in until a strobe with sync=1; that strobe SHALL be slot 0, the state SHALL move to LOCKED, and dac_in SHALL be captured as channel 1.
REQ-015 In LOCKED, expected slot SHALL be the previous slot+1, with wrap 23->0 (low 2->0 carrying into high; high 7, low 2 -> 0,0).
REQ-016 In LOCKED, SHALL sample dac_in into the shadow register ch[(slot/4)+1] on slots 0, 4, 8, 12, 16, 20 (channels 1..6); other slots SHALL NOT capture.
REQ-017 On a LOCKED slot-20 strobe with all five earlier captures of the frame made since the last slot 0, ch_out SHALL load {dac_in, shadow ch5..ch1} at that edge, and frame_valid SHALL be 1 for exactly the following cycle.
REQ-018 ch_out SHALL hold its value at all other times; the first frame after lock SHALL update ch_out only when it completes.
REQ-019 Early sync: a LOCKED strobe with sync=1 and expected slot not 0 SHALL set sync_err, resynchronise to slot 0, discard the partial frame, capture dac_in as channel 1, and remain LOCKED.
REQ-020 Missing sync: a LOCKED strobe with expected slot 0 and sync=0 SHALL set sync_err, enter UNLOCKED, and perform no capture.
REQ-021 err_clr=1 SHALL clear sync_err at the next edge; if a new error occurs on the same edge, sync_err SHALL be 1 (error wins).
REQ-022 frame_valid SHALL never be high on two consecutive cycles.
REQ-023 The design SHALL be fully synchronous to MCLK, with no latches or combinational paths from inputs to outputs.

Reset
REQ-024 While reset=1, the next edge SHALL set: state UNLOCKED, slot counter 0, shadow registers 0, ch_out 0, frame_valid 0, locked 0, sync_err 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, no capture SHALL occur until the next sync strobe.

Verification
REQ-026 Basic frame: reset; then 24 strobes with sync on the first and dac_in=slot index -> frame_valid one cycle after the slot-20 strobe; ch_out = {20,16,12,8,4,0}; locked=1.
REQ-027 Wrap: three back-to-back frames with correct sync, dac_in=0x1FF (-1) on every slot -> three frame_valid pulses 24 strobes apart; ch_out all 0x1FF; sync_err=0.
REQ-028 Early sync: sync asserted at slot 10, then a clean frame -> sync_err=1 after that strobe; no frame_valid for the aborted frame; the next complete frame updates ch_out; locked stays 1.
REQ-029 Missing sync: sync withheld at the expected slot 0 -> locked=0 and sync_err=1 at that edge; dac_in ignored until the next sync.
REQ-030 Error clear race: err_clr=1 on the same strobe as an early sync -> sync_err=1; err_clr alone one cycle later -> sync_err=0.
REQ-031 Reset mid-frame at slot 12, then release -> all outputs 0; a sync-less strobe does not lock; the next sync locks at slot 0.
